// File: rtl/arb_requester.sv
// Two-channel burst initiator for a 2-way grant arbiter.
// Each channel raises req for one burst, counts granted beats, then waits out the trailing grant.
module arb_requester #(
  parameter int LEN_W    = 4,
  parameter int WAIT_MAX = 31
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid_0,
  input  logic [LEN_W-1:0] cmd_len_0,
  output logic             cmd_ready_0,
  input  logic             cmd_valid_1,
  input  logic [LEN_W-1:0] cmd_len_1,
  output logic             cmd_ready_1,
  output logic             req_0,
  output logic             req_1,
  input  logic             gnt_0,
  input  logic             gnt_1,
  output logic             beat_0,
  output logic             beat_1,
  output logic             done_0,
  output logic             done_1,
  output logic             timeout_0,
  output logic             timeout_1,
  output logic             proto_err,
  input  logic             err_clear
);

  localparam int WCW = $clog2(WAIT_MAX + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);
  localparam logic [LEN_W:0] REM_ONE = (LEN_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, REQ, OWN, DRAIN} state_t;

  logic [1:0]       cmd_valid;
  logic [LEN_W-1:0] cmd_len [2];
  logic [1:0]       gnt;
  logic [1:0]       cmd_ready;
  logic [1:0]       req;
  logic [1:0]       beat;
  logic [1:0]       done;
  logic [1:0]       timeout;
  logic [1:0]       idle_gnt;
  logic [1:0]       own_drop;
  logic             proto_set;

  assign cmd_valid  = {cmd_valid_1, cmd_valid_0};
  assign cmd_len[0] = cmd_len_0;
  assign cmd_len[1] = cmd_len_1;
  assign gnt        = {gnt_1, gnt_0};

  for (genvar c = 0; c < 2; c++) begin : g_ch
    state_t         st_q, st_d;
    logic [LEN_W:0] rem_q, rem_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic           done_q, done_d;
    logic           tout_q, tout_d;
    logic           drop_d;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        st_q   <= IDLE;
        rem_q  <= '0;
        wait_q <= '0;
        done_q <= 1'b0;
        tout_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        rem_q  <= rem_d;
        wait_q <= wait_d;
        done_q <= done_d;
        tout_q <= tout_d;
      end
    end

    always_comb begin
      st_d   = st_q;
      rem_d  = rem_q;
      wait_d = wait_q;
      done_d = 1'b0;
      tout_d = 1'b0;
      drop_d = 1'b0;
      case (st_q)
        IDLE: begin
          if (cmd_valid[c]) begin
            rem_d  = {1'b0, cmd_len[c]} + REM_ONE;
            wait_d = '0;
            st_d   = REQ;
          end
        end
        REQ: begin
          if (gnt[c]) begin
            rem_d = rem_q - REM_ONE;
            if (rem_q == REM_ONE) begin
              st_d   = DRAIN;
              done_d = 1'b1;
            end else begin
              st_d = OWN;
            end
          end else if (wait_q == WAIT_LAST) begin
            st_d   = DRAIN;
            tout_d = 1'b1;
          end else begin
            wait_d = wait_q + WCW'(1);
          end
        end
        OWN: begin
          if (gnt[c]) begin
            rem_d = rem_q - REM_ONE;
            if (rem_q == REM_ONE) begin
              st_d   = DRAIN;
              done_d = 1'b1;
            end
          end else begin
            // Arbiter withdrew grant before the burst finished.
            drop_d = 1'b1;
            st_d   = DRAIN;
          end
        end
        DRAIN: begin
          if (!gnt[c]) st_d = IDLE;
        end
        default: st_d = IDLE;
      endcase
    end

    assign req[c]       = (st_q == REQ) || (st_q == OWN);
    assign cmd_ready[c] = (st_q == IDLE);
    assign beat[c]      = req[c] & gnt[c];
    assign done[c]      = done_q;
    assign timeout[c]   = tout_q;
    assign idle_gnt[c]  = (st_q == IDLE) & gnt[c];
    assign own_drop[c]  = drop_d;
  end

  assign proto_set = (|idle_gnt) | (&gnt) | (|own_drop);

  // Set dominates a simultaneous clear so no violation is ever lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) proto_err <= 1'b0;
    else       proto_err <= proto_set | (proto_err & ~err_clear);
  end

  assign cmd_ready_0 = cmd_ready[0];
  assign cmd_ready_1 = cmd_ready[1];
  assign req_0       = req[0];
  assign req_1       = req[1];
  assign beat_0      = beat[0];
  assign beat_1      = beat[1];
  assign done_0      = done[0];
  assign done_1      = done[1];
  assign timeout_0   = timeout[0];
  assign timeout_1   = timeout[1];

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester with a behavioural registered-grant arbiter and a beat scoreboard.
module tb_arb_requester;
  localparam int LEN_W    = 4;
  localparam int WAIT_MAX = 31;

  logic             clock = 1'b0;
  logic             reset;
  logic             cmd_valid_0, cmd_valid_1;
  logic [LEN_W-1:0] cmd_len_0, cmd_len_1;
  logic             cmd_ready_0, cmd_ready_1;
  logic             req_0, req_1;
  logic             gnt_0, gnt_1;
  logic             beat_0, beat_1;
  logic             done_0, done_1;
  logic             timeout_0, timeout_1;
  logic             proto_err;
  logic             err_clear;

  always #5 clock = ~clock;

  arb_requester #(.LEN_W(LEN_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid_0(cmd_valid_0), .cmd_len_0(cmd_len_0), .cmd_ready_0(cmd_ready_0),
    .cmd_valid_1(cmd_valid_1), .cmd_len_1(cmd_len_1), .cmd_ready_1(cmd_ready_1),
    .req_0(req_0), .req_1(req_1), .gnt_0(gnt_0), .gnt_1(gnt_1),
    .beat_0(beat_0), .beat_1(beat_1), .done_0(done_0), .done_1(done_1),
    .timeout_0(timeout_0), .timeout_1(timeout_1),
    .proto_err(proto_err), .err_clear(err_clear)
  );

  // Arbiter model: registered request, grant held by owner, grant falls one cycle after req falls.
  logic r0, r1, gm0, gm1, g0n, g1n;
  logic kill0 = 1'b0, kill1 = 1'b0, force0 = 1'b0, force1 = 1'b0;
  assign g0n = r0 & req_0 & (gm0 | ~gm1);
  assign g1n = r1 & req_1 & (gm1 | (~gm0 & ~g0n));
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r0 <= 1'b0; r1 <= 1'b0; gm0 <= 1'b0; gm1 <= 1'b0;
    end else begin
      r0 <= req_0; r1 <= req_1; gm0 <= g0n; gm1 <= g1n;
    end
  end
  assign gnt_0 = (gm0 & ~kill0) | force0;
  assign gnt_1 = (gm1 & ~kill1) | force1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected beat counts per accepted command, popped on each done pulse.
  int exp_q0[$];
  int exp_q1[$];
  int cyc = 0;
  int beat_acc[2], done_n[2], tout_n[2], reqh_n[2], done_cyc[2], tout_cyc[2];
  logic [1:0] mon_beat, mon_req, mon_done, mon_tout, mon_ready;
  assign mon_beat  = {beat_1, beat_0};
  assign mon_req   = {req_1, req_0};
  assign mon_done  = {done_1, done_0};
  assign mon_tout  = {timeout_1, timeout_0};
  assign mon_ready = {cmd_ready_1, cmd_ready_0};

  task automatic sb_pop(input int c);
    int e;
    if (c == 0) begin
      chk("sb0_pending", 32'(exp_q0.size() > 0), 32'd1);
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        chk("sb0_beats", 32'(beat_acc[0]), 32'(e));
      end
    end else begin
      chk("sb1_pending", 32'(exp_q1.size() > 0), 32'd1);
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        chk("sb1_beats", 32'(beat_acc[1]), 32'(e));
      end
    end
  endtask

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        beat_acc[c] = 0;
      end else begin
        if (mon_ready[c]) beat_acc[c] = 0;
        if (mon_beat[c])  beat_acc[c]++;
        if (mon_req[c])   reqh_n[c]++;
        if (mon_done[c]) begin
          done_n[c]++;
          done_cyc[c] = cyc;
          sb_pop(c);
        end
        if (mon_tout[c]) begin
          tout_n[c]++;
          tout_cyc[c] = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, d0, d1, t0, t1, rq, w;
    logic [11:0] rv, bv, dv, yv;
    for (int c = 0; c < 2; c++) begin
      beat_acc[c] = 0; done_n[c] = 0; tout_n[c] = 0;
      reqh_n[c] = 0; done_cyc[c] = 0; tout_cyc[c] = 0;
    end
    reset = 1'b1;
    cmd_valid_0 = 1'b0; cmd_valid_1 = 1'b0;
    cmd_len_0 = '0; cmd_len_1 = '0;
    err_clear = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    tick();
    chk("reset_outputs",
        32'({cmd_ready_1, cmd_ready_0, req_1, req_0, done_1, done_0, timeout_1, timeout_0, proto_err}),
        32'h180);

    // Single burst of 3 beats on channel 0
    cmd_valid_0 = 1'b1; cmd_len_0 = 4'd2; exp_q0.push_back(3);
    tick();
    cmd_valid_0 = 1'b0;
    a = cyc; d0 = done_n[0];
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      rv[i] = req_0; bv[i] = beat_0; dv[i] = done_0; yv[i] = cmd_ready_0;
      @(posedge clock);
    end
    #1;
    chk("single_req",   32'(rv), 32'h01F);
    chk("single_beat",  32'(bv), 32'h01C);
    chk("single_done",  32'(dv), 32'h020);
    chk("single_ready", 32'(yv), 32'hF80);
    chk("single_done_n", 32'(done_n[0] - d0), 32'd1);
    chk("single_proto", 32'(proto_err), 32'd0);

    // Contention: both channels accepted together
    d0 = done_n[0]; d1 = done_n[1]; t0 = tout_n[0]; t1 = tout_n[1];
    cmd_valid_0 = 1'b1; cmd_len_0 = 4'd3; exp_q0.push_back(4);
    cmd_valid_1 = 1'b1; cmd_len_1 = 4'd0; exp_q1.push_back(1);
    tick();
    chk("cont_both_req", 32'({req_1, req_0}), 32'h3);
    cmd_valid_0 = 1'b0; cmd_valid_1 = 1'b0;
    repeat (16) tick();
    chk("cont_done0_n", 32'(done_n[0] - d0), 32'd1);
    chk("cont_done1_n", 32'(done_n[1] - d1), 32'd1);
    chk("cont_order", 32'(done_cyc[1] - done_cyc[0]), 32'd3);
    chk("cont_no_tout", 32'((tout_n[0] - t0) + (tout_n[1] - t1)), 32'd0);
    chk("cont_ready", 32'({cmd_ready_1, cmd_ready_0, proto_err}), 32'h6);

    // Timeout on channel 1 with grant held low
    kill1 = 1'b1;
    d1 = done_n[1]; t1 = tout_n[1]; rq = reqh_n[1];
    cmd_valid_1 = 1'b1; cmd_len_1 = 4'd4;
    tick();
    cmd_valid_1 = 1'b0;
    a = cyc;
    repeat (36) tick();
    chk("tout_count", 32'(tout_n[1] - t1), 32'd1);
    chk("tout_when", 32'(tout_cyc[1] - a), 32'(WAIT_MAX));
    chk("tout_req_cycles", 32'(reqh_n[1] - rq), 32'(WAIT_MAX));
    chk("tout_no_done", 32'(done_n[1] - d1), 32'd0);
    chk("tout_idle", 32'({cmd_ready_1, req_1}), 32'h2);
    kill1 = 1'b0;
    tick();

    // Grant while idle, stickiness, clear, set-beats-clear, dual grant
    force0 = 1'b1;
    tick();
    force0 = 1'b0;
    chk("perr_idle_gnt", 32'(proto_err), 32'd1);
    repeat (3) tick();
    chk("perr_sticky", 32'(proto_err), 32'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("perr_clear", 32'(proto_err), 32'd0);
    force0 = 1'b1; err_clear = 1'b1;
    tick();
    force0 = 1'b0; err_clear = 1'b0;
    chk("perr_set_wins", 32'(proto_err), 32'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("perr_clear2", 32'(proto_err), 32'd0);
    force0 = 1'b1; force1 = 1'b1;
    tick();
    force0 = 1'b0; force1 = 1'b0;
    chk("perr_dual_gnt", 32'(proto_err), 32'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;

    // Grant dropped mid-burst after two beats
    d0 = done_n[0];
    cmd_valid_0 = 1'b1; cmd_len_0 = 4'd5;
    tick();
    cmd_valid_0 = 1'b0;
    w = 0;
    while (beat_acc[0] < 2 && w < 12) begin
      tick();
      w++;
    end
    chk("drop_two_beats", 32'(beat_acc[0]), 32'd2);
    chk("drop_pre_proto", 32'(proto_err), 32'd0);
    kill0 = 1'b1;
    tick();
    chk("drop_proto", 32'(proto_err), 32'd1);
    chk("drop_req_low", 32'(req_0), 32'd0);
    repeat (4) tick();
    chk("drop_no_done", 32'(done_n[0] - d0), 32'd0);
    chk("drop_ready", 32'(cmd_ready_0), 32'd1);
    kill0 = 1'b0;
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;

    // Asynchronous reset mid-burst
    d0 = done_n[0]; d1 = done_n[1];
    cmd_valid_0 = 1'b1; cmd_len_0 = 4'd7; exp_q0.push_back(8);
    cmd_valid_1 = 1'b1; cmd_len_1 = 4'd7; exp_q1.push_back(8);
    tick();
    cmd_valid_0 = 1'b0; cmd_valid_1 = 1'b0;
    repeat (4) tick();
    chk("arst_pre_req", 32'({req_1, req_0}), 32'h3);
    #2 reset = 1'b1;
    #1;
    chk("arst_outputs",
        32'({req_1, req_0, beat_1, beat_0, done_1, done_0, timeout_1, timeout_0}), 32'h0);
    exp_q0.delete();
    exp_q1.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    tick();
    chk("arst_release", 32'({cmd_ready_1, cmd_ready_0, proto_err}), 32'h6);
    chk("arst_no_done", 32'((done_n[0] - d0) + (done_n[1] - d1)), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
- Two-channel initiator that drives the req_0/req_1 side of the 2-way grant arbiter and consumes its gnt_0/gnt_1.
- Each channel accepts a burst command (valid/ready), raises req, and counts granted beats. It then drops req and waits for the arbiter's trailing grant to clear before taking the next command.
- Includes per-channel grant timeout and sticky protocol-error detection.
- Sits between command sources and the arbiter.

Parameters:
- LEN_W, 4, width of burst length field; burst = cmd_len+1 beats (1..2^LEN_W).
- WAIT_MAX, 31, max REQ-state cycles without grant before timeout; must exceed 2^LEN_W+4.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid_0  in  1  channel 0 command valid
- cmd_len_0  in  LEN_W  channel 0 burst length minus one
- cmd_ready_0  out  1  channel 0 idle, can accept
- cmd_valid_1, cmd_len_1, cmd_ready_1: same for channel 1
- req_0, req_1  out  1  requests to arbiter
- gnt_0, gnt_1  in  1  grants from arbiter
- beat_0, beat_1  out  1  granted transfer cycle for channel
- done_0, done_1  out  1  one-cycle pulse: burst completed
- timeout_0, timeout_1  out  1  one-cycle pulse: grant wait expired
- proto_err  out  1  sticky protocol violation flag
- err_clear  in  1  clears proto_err

Behaviour:
- Reset, asynchronous, all registers: states=IDLE, req=0, done=0, timeout=0, proto_err=0, counters=0. cmd_ready=1 after reset deasserts.
- Per-channel FSM with states IDLE, REQ, OWN, DRAIN. Both channels are identical and independent except for the shared proto_err.
- Output decodes from state:
  - req_x = state in {REQ, OWN}, decoded directly from the state register.
  - cmd_ready_x = state==IDLE.
  - beat_x = (state in {REQ, OWN}) & gnt_x, combinational.
- IDLE: on cmd_valid_x & cmd_ready_x, latch remaining=cmd_len_x+1, clear wait_cnt, go to REQ. req_x is high in the next cycle.
- REQ:
  - If gnt_x is low, increment wait_cnt. When wait_cnt==WAIT_MAX-1 and gnt_x is still low: pulse timeout_x next cycle, go to DRAIN.
  - If gnt_x is high, the cycle is a beat: decrement remaining. Go to OWN, or to DRAIN if remaining was 1.
- OWN:
  - Each cycle with gnt_x high is a beat: decrement remaining. On the beat with remaining==1, go to DRAIN and pulse done_x next cycle.
  - If gnt_x is low in OWN: set proto_err, go to DRAIN, no done.
- DRAIN: req_x=0. Stay until gnt_x is sampled low, then go to IDLE. The arbiter's registered grant trails req by 2 cycles; trailing gnt_x in DRAIN is legal and is not a beat.
- proto_err is set by any of:
  - gnt_x high while channel x is in IDLE.
  - gnt_0 & gnt_1 high in the same cycle.
  - Grant dropped in OWN.
- proto_err clears only on err_clear. If set and clear occur in the same cycle, set wins.
- Expected latency with an idle arbiter:
  - Command accepted at edge k; req high after edge k.
  - First gnt seen after edge k+2; beats on consecutive cycles.
  - done_x pulses the cycle after the last beat edge.
  - cmd_ready_x returns 2 cycles after req_x falls.
- Simultaneous commands on both channels are accepted in the same cycle. The arbiter serializes them; the losing channel waits in REQ, subject to timeout.
- Reset mid-burst drops req immediately (asynchronous). The in-flight command is discarded with no done pulse.
- Counter widths: remaining is LEN_W+1 bits; wait_cnt is ceil(log2(WAIT_MAX+1)) bits. Neither wraps: both are bounded by FSM exits.

Test Plan:
- Single burst. Idle arbiter model, cmd_len_0=2 accepted at edge 0 → req_0 high for 5 cycles, beat_0 high for 3 consecutive cycles starting after edge 2, one done_0 pulse, cmd_ready_0 high again 2 cycles after req_0 falls, proto_err=0.
- Contention. cmd_len_0=3 and cmd_len_1=0 accepted in the same cycle → 4 beats on channel 0, then 1 beat on channel 1 after gnt_0 clears. done_0 is followed by done_1; no timeout.
- Timeout. WAIT_MAX=31, gnt_1 held low with cmd on channel 1 → timeout_1 pulses exactly once after 31 REQ cycles, req_1 drops, cmd_ready_1 returns once gnt_1 is low, no done_1.
- Protocol errors.
  - gnt_0 high while channel 0 is IDLE → proto_err=1 and stays set. err_clear pulse → 0.
  - gnt_0 and gnt_1 high together → proto_err=1.
- Grant drop. gnt_0 forced low mid-burst (cmd_len_0=5, after 2 beats) → proto_err=1, req_0 drops next cycle, no done_0.
- Asynchronous reset. reset asserted mid-burst between clock edges → req_0, req_1 and the pulse outputs go 0 without a clock edge. After release: both cmd_ready=1, proto_err=0.
